grid_arbiter: RTL and testbench



---
 rtl/lightbike_pkg.sv | 23 ++
 rtl/grid_arbiter_if.sv | 39 +++
 rtl/grid_clear_sweeper.sv | 40 ++++
 rtl/grid_arbiter.sv | 154 +++++++++++++++
 tb/tb_grid_arbiter.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lightbike_pkg.sv
// rtl/lightbike_pkg.sv - shared lightbike grid constants, arbiter states and border-cell helper
package lightbike_pkg;

  localparam int GRID_SIZE = 32;
  localparam int LOG_GRID  = 5;
  localparam int ADDR_W    = 2 * LOG_GRID;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_P_RD  = 2'd1,
    ST_P_WR  = 2'd2,
    ST_CLEAR = 2'd3
  } arb_state_e;

  // Cells on the outer ring are walls after a round clear.
  function automatic logic is_border(input logic [LOG_GRID-1:0] x,
                                     input logic [LOG_GRID-1:0] y);
    logic [LOG_GRID-1:0] edge_c;
    edge_c = LOG_GRID'(GRID_SIZE - 1);
    return (x == '0) || (x == edge_c) || (y == '0) || (y == edge_c);
  endfunction

endpackage

// File: rtl/grid_arbiter_if.sv
// rtl/grid_arbiter_if.sv - requester and grid RAM signals around the lightbike grid arbiter
interface grid_arbiter_if
  import lightbike_pkg::*;
();

  logic                  pix_req;
  logic [LOG_GRID-1:0]   pix_x;
  logic [LOG_GRID-1:0]   pix_y;
  logic                  pix_valid;
  logic                  pix_data;

  logic                  clr_start;
  logic                  clr_busy;

  logic [1:0]            p_req;
  logic [2*LOG_GRID-1:0] p_x;
  logic [2*LOG_GRID-1:0] p_y;
  logic [1:0]            p_gnt;
  logic [1:0]            p_done;
  logic                  p_hit;

  logic [ADDR_W-1:0]     mem_addr;
  logic                  mem_we;
  logic                  mem_wdata;
  logic                  mem_rdata;

  modport slave (
    input  pix_req, pix_x, pix_y, clr_start, p_req, p_x, p_y, mem_rdata,
    output pix_valid, pix_data, clr_busy, p_gnt, p_done, p_hit,
           mem_addr, mem_we, mem_wdata
  );

  modport master (
    output pix_req, pix_x, pix_y, clr_start, p_req, p_x, p_y, mem_rdata,
    input  pix_valid, pix_data, clr_busy, p_gnt, p_done, p_hit,
           mem_addr, mem_we, mem_wdata
  );

endinterface

// File: rtl/grid_clear_sweeper.sv
// rtl/grid_clear_sweeper.sv - round-clear address counter producing the border wall pattern
module grid_clear_sweeper
  import lightbike_pkg::*;
#(
  parameter int GRID_SIZE = lightbike_pkg::GRID_SIZE,
  parameter int LOG_GRID  = lightbike_pkg::LOG_GRID
) (
  input  logic                  board_clk,
  input  logic                  reset,
  input  logic                  en_i,
  output logic [2*LOG_GRID-1:0] addr_o,
  output logic                  wdata_o,
  output logic                  last_o
);

  localparam logic [2*LOG_GRID-1:0] LAST_ADDR = (2*LOG_GRID)'(GRID_SIZE * GRID_SIZE - 1);

  logic [2*LOG_GRID-1:0] cnt_q, cnt_d;

  assign addr_o  = cnt_q;
  assign last_o  = (cnt_q == LAST_ADDR);
  assign wdata_o = is_border(cnt_q[LOG_GRID-1:0], cnt_q[2*LOG_GRID-1:LOG_GRID]);

  // Wrapping to zero on the final write leaves the counter ready for the next round.
  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      cnt_d = last_o ? '0 : cnt_q + (2*LOG_GRID)'(1);
    end
  end

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/grid_arbiter.sv
// rtl/grid_arbiter.sv - single-port grid RAM arbiter: VGA reads, round clear, atomic player commits
module grid_arbiter
  import lightbike_pkg::*;
#(
  parameter int GRID_SIZE = lightbike_pkg::GRID_SIZE,
  parameter int LOG_GRID  = lightbike_pkg::LOG_GRID
) (
  input  logic          board_clk,
  input  logic          reset,
  grid_arbiter_if.slave bus
);

  arb_state_e            state_q, state_d;
  logic                  cur_q, cur_d;
  logic                  rr_q, rr_d;
  logic [LOG_GRID-1:0]   x_q, x_d;
  logic [LOG_GRID-1:0]   y_q, y_d;
  logic                  rd_pend_q, rd_pend_d;
  logic                  hit_q, hit_d;
  logic                  pix_valid_q;

  logic                  sel;
  logic [LOG_GRID-1:0]   gx, gy;
  logic [1:0]            gnt_c, done_c;
  logic                  hit_c;
  logic [2*LOG_GRID-1:0] addr_c;
  logic                  we_c, wdata_c;
  logic                  sweep_en;
  logic [2*LOG_GRID-1:0] sweep_addr;
  logic                  sweep_wdata, sweep_last;

  grid_clear_sweeper #(
    .GRID_SIZE (GRID_SIZE),
    .LOG_GRID  (LOG_GRID)
  ) u_sweeper (
    .board_clk (board_clk),
    .reset     (reset),
    .en_i      (sweep_en),
    .addr_o    (sweep_addr),
    .wdata_o   (sweep_wdata),
    .last_o    (sweep_last)
  );

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    rr_d      = rr_q;
    x_d       = x_q;
    y_d       = y_q;
    rd_pend_d = 1'b0;
    hit_d     = rd_pend_q ? bus.mem_rdata : hit_q;
    gnt_c     = 2'b00;
    done_c    = 2'b00;
    hit_c     = 1'b0;
    addr_c    = '0;
    we_c      = 1'b0;
    wdata_c   = 1'b0;
    sweep_en  = 1'b0;

    // The pointer only moves on contention, so a lone requester never steals the next tie.
    sel = (bus.p_req == 2'b11) ? ~rr_q : bus.p_req[1];
    gx  = sel ? bus.p_x[2*LOG_GRID-1:LOG_GRID] : bus.p_x[LOG_GRID-1:0];
    gy  = sel ? bus.p_y[2*LOG_GRID-1:LOG_GRID] : bus.p_y[LOG_GRID-1:0];

    if (bus.pix_req) begin
      addr_c = {bus.pix_y, bus.pix_x};
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.clr_start) begin
          state_d = ST_CLEAR;
        end else if (bus.p_req != 2'b00) begin
          gnt_c[sel] = 1'b1;
          cur_d      = sel;
          x_d        = gx;
          y_d        = gy;
          if (bus.p_req == 2'b11) begin
            rr_d = sel;
          end
          if (bus.pix_req) begin
            state_d = ST_P_RD;
          end else begin
            addr_c    = {gy, gx};
            rd_pend_d = 1'b1;
            state_d   = ST_P_WR;
          end
        end
      end
      ST_P_RD: begin
        if (!bus.pix_req) begin
          addr_c    = {y_q, x_q};
          rd_pend_d = 1'b1;
          state_d   = ST_P_WR;
        end
      end
      ST_P_WR: begin
        if (!bus.pix_req) begin
          addr_c        = {y_q, x_q};
          we_c          = 1'b1;
          wdata_c       = 1'b1;
          done_c[cur_q] = 1'b1;
          hit_c         = rd_pend_q ? bus.mem_rdata : hit_q;
          state_d       = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (!bus.pix_req) begin
          sweep_en = 1'b1;
          addr_c   = sweep_addr;
          we_c     = 1'b1;
          wdata_c  = sweep_wdata;
          if (sweep_last) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cur_q       <= 1'b0;
      rr_q        <= 1'b1;
      x_q         <= '0;
      y_q         <= '0;
      rd_pend_q   <= 1'b0;
      hit_q       <= 1'b0;
      pix_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      rr_q        <= rr_d;
      x_q         <= x_d;
      y_q         <= y_d;
      rd_pend_q   <= rd_pend_d;
      hit_q       <= hit_d;
      pix_valid_q <= bus.pix_req;
    end
  end

  assign bus.mem_addr  = addr_c;
  assign bus.mem_we    = we_c;
  assign bus.mem_wdata = wdata_c;
  assign bus.p_gnt     = gnt_c;
  assign bus.p_done    = done_c;
  assign bus.p_hit     = hit_c;
  assign bus.pix_valid = pix_valid_q;
  assign bus.pix_data  = pix_valid_q & bus.mem_rdata;
  assign bus.clr_busy  = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_grid_arbiter.sv
// tb/tb_grid_arbiter.sv - scoreboard bench for grid_arbiter with a 1-cycle-latency RAM model
module tb_grid_arbiter;

  typedef struct packed {
    logic pl;
    logic hit;
  } sb_t;

  logic board_clk = 1'b0;
  logic reset     = 1'b1;
  int   cyc       = 0;
  int   n_cmp     = 0;
  int   n_err     = 0;

  grid_arbiter_if bus ();

  grid_arbiter dut (
    .board_clk (board_clk),
    .reset     (reset),
    .bus       (bus)
  );

  always #5 board_clk = ~board_clk;
  always @(posedge board_clk) cyc <= cyc + 1;

  logic ram [0:1023] = '{default: 1'b0};
  logic rdata_q      = 1'b0;
  bit   shadow [0:1023];

  always @(posedge board_clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    rdata_q <= ram[bus.mem_addr];
  end
  assign bus.mem_rdata = rdata_q;

  sb_t  sbq [$];
  logic pixq [$];
  sb_t  mon_s;
  logic mon_p;
  int   gcyc [2];
  int   dcyc [2];
  int   rcyc;
  int   busy_cnt;
  int   nbad;
  int   n;
  logic busy_seen;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit tb_border(input int a);
    int x, y;
    x = a % 32;
    y = a / 32;
    return (x == 0) || (x == 31) || (y == 0) || (y == 31);
  endfunction

  task automatic tick();
    @(posedge board_clk);
    #1;
  endtask

  task automatic push_commit(input int pl, input int x, input int y);
    int a;
    sb_t s;
    a     = y * 32 + x;
    s.pl  = pl[0];
    s.hit = shadow[a];
    sbq.push_back(s);
    shadow[a] = 1'b1;
    bus.p_x[pl*5 +: 5] = x[4:0];
    bus.p_y[pl*5 +: 5] = y[4:0];
    bus.p_req[pl]      = 1'b1;
  endtask

  task automatic wait_all(input logic [1:0] mask);
    logic [1:0] pend;
    int k;
    pend = mask;
    k    = 0;
    for (int p = 0; p < 2; p++) if (mask[p]) begin gcyc[p] = -1000; dcyc[p] = -1000; end
    while (pend != 2'b00 && k < 100) begin
      @(negedge board_clk);
      k++;
      for (int p = 0; p < 2; p++) begin
        if (bus.p_gnt[p]) gcyc[p] = cyc;
        if (pend[p] && bus.p_done[p]) begin
          dcyc[p]       = cyc;
          pend[p]       = 1'b0;
          bus.p_req[p]  = 1'b0;
        end
      end
    end
    if (pend != 2'b00) chk("txn_timeout", {30'd0, pend}, 32'd0);
  endtask

  task automatic pix_one(input int x, input int y);
    bus.pix_req = 1'b1;
    bus.pix_x   = x[4:0];
    bus.pix_y   = y[4:0];
    pixq.push_back(shadow[y*32 + x]);
  endtask

  task automatic pix_burst(input int delay);
    int px [3] = '{0, 5, 31};
    int py [3] = '{9, 5, 2};
    repeat (delay) tick();
    for (int i = 0; i < 3; i++) begin
      pix_one(px[i], py[i]);
      tick();
    end
    bus.pix_req = 1'b0;
  endtask

  always @(negedge board_clk) begin
    if (bus.pix_valid) begin
      if (pixq.size() == 0) chk("pix_unexpected", 32'd1, 32'd0);
      else begin
        mon_p = pixq.pop_front();
        chk("pix_data", {31'd0, bus.pix_data}, {31'd0, mon_p});
      end
    end
    if (bus.p_done != 2'b00) begin
      if (sbq.size() == 0) chk("done_unexpected", {30'd0, bus.p_done}, 32'd0);
      else begin
        mon_s = sbq.pop_front();
        chk("done_player", {30'd0, bus.p_done}, mon_s.pl ? 32'd2 : 32'd1);
        chk("p_hit", {31'd0, bus.p_hit}, {31'd0, mon_s.hit});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    bus.pix_req   = 1'b0;
    bus.pix_x     = '0;
    bus.pix_y     = '0;
    bus.clr_start = 1'b0;
    bus.p_req     = 2'b00;
    bus.p_x       = '0;
    bus.p_y       = '0;

    repeat (3) @(posedge board_clk);
    @(negedge board_clk);
    chk("rst_clr_busy",  {31'd0, bus.clr_busy},  32'd0);
    chk("rst_mem_we",    {31'd0, bus.mem_we},    32'd0);
    chk("rst_mem_addr",  {22'd0, bus.mem_addr},  32'd0);
    chk("rst_mem_wdata", {31'd0, bus.mem_wdata}, 32'd0);
    chk("rst_p_gnt",     {30'd0, bus.p_gnt},     32'd0);
    chk("rst_p_done",    {30'd0, bus.p_done},    32'd0);
    chk("rst_p_hit",     {31'd0, bus.p_hit},     32'd0);
    chk("rst_pix_valid", {31'd0, bus.pix_valid}, 32'd0);
    @(posedge board_clk);
    #1 reset = 1'b0;
    tick();

    // Full round clear with an idle VGA.
    bus.clr_start = 1'b1;
    tick();
    bus.clr_start = 1'b0;
    busy_cnt = 0;
    n = 0;
    while (n < 3000) begin
      @(negedge board_clk);
      n++;
      if (bus.clr_busy) busy_cnt++;
      else if (busy_cnt > 0) break;
    end
    chk("clr_cycles", busy_cnt, 32'd1024);
    for (int a = 0; a < 1024; a++) shadow[a] = tb_border(a);
    chk("cell_0_5",   {31'd0, ram[5*32 + 0]},   32'd1);
    chk("cell_31_31", {31'd0, ram[31*32 + 31]}, 32'd1);
    chk("cell_10_10", {31'd0, ram[10*32 + 10]}, 32'd0);
    nbad = 0;
    for (int a = 0; a < 1024; a++) if (ram[a] !== shadow[a]) nbad++;
    chk("clr_pattern", nbad, 32'd0);

    // Uncontended P1 commit, read-back through the VGA port, then a repeat.
    tick();
    push_commit(0, 10, 10);
    rcyc = cyc;
    wait_all(2'b01);
    chk("p1_gnt_cycle", gcyc[0] - rcyc, 32'd0);
    chk("p1_latency", dcyc[0] - gcyc[0], 32'd1);
    tick();
    pix_one(10, 10);
    tick();
    bus.pix_req = 1'b0;
    tick();
    push_commit(0, 10, 10);
    wait_all(2'b01);

    // Head-on collision pairs; the tie alternates.
    tick();
    push_commit(0, 12, 7);
    push_commit(1, 12, 7);
    rcyc = cyc;
    wait_all(2'b11);
    chk("pair1_p1_first", gcyc[0] - rcyc, 32'd0);
    chk("pair1_p2_next", gcyc[1] - dcyc[0], 32'd1);
    chk("pair1_p2_lat", dcyc[1] - gcyc[1], 32'd1);
    tick();
    push_commit(1, 3, 20);
    push_commit(0, 3, 20);
    rcyc = cyc;
    wait_all(2'b11);
    chk("pair2_p2_first", gcyc[1] - rcyc, 32'd0);
    chk("pair2_p1_next", gcyc[0] - dcyc[1], 32'd1);

    // VGA stalls the read phase, then the write phase.
    tick();
    push_commit(0, 20, 20);
    rcyc = cyc;
    fork
      wait_all(2'b01);
      pix_burst(0);
    join
    chk("stall_rd_gnt", gcyc[0] - rcyc, 32'd0);
    chk("stall_rd_lat", dcyc[0] - gcyc[0], 32'd4);
    tick();
    push_commit(0, 20, 20);
    fork
      wait_all(2'b01);
      pix_burst(1);
    join
    chk("stall_wr_lat", dcyc[0] - gcyc[0], 32'd4);

    // Border cell hit, with a clear request landing mid-transaction.
    tick();
    push_commit(0, 0, 4);
    fork
      wait_all(2'b01);
      begin
        tick();
        bus.clr_start = 1'b1;
        tick();
        bus.clr_start = 1'b0;
      end
    join
    busy_seen = 1'b0;
    repeat (4) begin
      @(negedge board_clk);
      busy_seen |= bus.clr_busy;
    end
    chk("clr_ignored", {31'd0, busy_seen}, 32'd0);

    // Reset in the middle of a sweep.
    tick();
    bus.clr_start = 1'b1;
    tick();
    bus.clr_start = 1'b0;
    n = 0;
    while (n < 2000) begin
      @(negedge board_clk);
      n++;
      if (bus.mem_we && bus.mem_addr == 10'd500) break;
    end
    chk("sweep_at_500", {22'd0, bus.mem_addr}, 32'd500);
    reset = 1'b1;
    #1;
    chk("rst_mid_busy", {31'd0, bus.clr_busy}, 32'd0);
    chk("rst_mid_we",   {31'd0, bus.mem_we},   32'd0);
    for (int a = 0; a < 500; a++) shadow[a] = tb_border(a);
    @(posedge board_clk);
    #1 reset = 1'b0;
    push_commit(1, 3, 20);
    rcyc = cyc;
    wait_all(2'b10);
    chk("p2_gnt_after_rst", {31'd0, (gcyc[1] >= rcyc) && (gcyc[1] <= rcyc + 1)}, 32'd1);

    repeat (3) tick();
    chk("sb_drained",  sbq.size(),  32'd0);
    chk("pix_drained", pixq.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
